// File: rtl/sonic_dma_irq_pkg.sv
// sonic_dma_irq_pkg: shared FSM state type, count width and ring occupancy helper.
// Revision 1.0
`default_nettype none

package sonic_dma_irq_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } irq_state_e;

  // Out-of-range pointers report an empty ring rather than a bogus count.
  function automatic logic [CNT_W-1:0] ring_occupancy(
    input logic [CNT_W-1:0] wr_ptr,
    input logic [CNT_W-1:0] rd_ptr,
    input logic [CNT_W-1:0] depth
  );
    if ((wr_ptr >= depth) || (rd_ptr >= depth)) begin
      return '0;
    end else if (wr_ptr >= rd_ptr) begin
      return wr_ptr - rd_ptr;
    end else begin
      return wr_ptr + depth - rd_ptr;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/sonic_dma_irq_chan.sv
// sonic_dma_irq_chan: one ring's occupancy register and IDLE/ARMED/FIRE coalescing FSM.
// Revision 1.0 -- SONIC_IRQ_TIMEOUT_EN builds the ARMED timeout timer.
`default_nettype none

module sonic_dma_irq_chan
  import sonic_dma_irq_pkg::*;
#(
  parameter int PTR_W      = 15,
  parameter int RING_DEPTH = 25600,
  parameter int TMO_W      = 16
) (
  input  logic             clk_in,
  input  logic             rstn,
  input  logic [PTR_W-1:0] wp,
  input  logic [PTR_W-1:0] rp,
  input  logic [PTR_W-1:0] threshold,
  input  logic [TMO_W-1:0] timeout,
  input  logic             ack,
  output logic [CNT_W-1:0] avail,
  output logic             status
);

  logic [CNT_W-1:0] avail_d, avail_q;
  logic [CNT_W-1:0] thr_eff;
  irq_state_e       state_d, state_q;
  logic             status_d, status_q;
  logic             tmo_hit;

`ifdef SONIC_IRQ_TIMEOUT_EN
  logic [TMO_W-1:0] timer_d, timer_q;

  // Compare against the post-increment value so FIRE lands exactly timeout cycles after entry.
  assign tmo_hit = (timeout != '0) &&
                   (({1'b0, timer_q} + {{TMO_W{1'b0}}, 1'b1}) >= {1'b0, timeout});
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign tmo_hit        = 1'b0;
`endif

  assign thr_eff = (threshold == '0) ? CNT_W'(1) : CNT_W'(threshold);

  always_comb begin
    avail_d = ring_occupancy(CNT_W'(wp), CNT_W'(rp), CNT_W'(RING_DEPTH));
    state_d = state_q;
`ifdef SONIC_IRQ_TIMEOUT_EN
    timer_d = timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (avail_q >= thr_eff) begin
          state_d = FIRE;
        end else if (avail_q != '0) begin
          state_d = ARMED;
`ifdef SONIC_IRQ_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      ARMED: begin
        if (avail_q >= thr_eff) begin
          state_d = FIRE;
        end else if (avail_q == '0) begin
          state_d = IDLE;
        end else if (tmo_hit) begin
          state_d = FIRE;
        end else begin
`ifdef SONIC_IRQ_TIMEOUT_EN
          timer_d = (timer_q == '1) ? timer_q : timer_q + TMO_W'(1);
`endif
        end
      end
      FIRE: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    status_d = (state_d == FIRE);
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      avail_q  <= '0;
      state_q  <= IDLE;
      status_q <= 1'b0;
`ifdef SONIC_IRQ_TIMEOUT_EN
      timer_q  <= '0;
`endif
    end else begin
      avail_q  <= avail_d;
      state_q  <= state_d;
      status_q <= status_d;
`ifdef SONIC_IRQ_TIMEOUT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign avail  = avail_q;
  assign status = status_q;

endmodule

`default_nettype wire

// File: rtl/sonic_dma_irq_coalescer.sv
// sonic_dma_irq_coalescer: per-channel DMA ring occupancy and coalesced interrupt generation.
// Revision 1.0 -- SONIC_IRQ_TIMEOUT_EN enables the per-channel coalescing timeout.
`default_nettype none

module sonic_dma_irq_coalescer
  import sonic_dma_irq_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int PTR_W      = 15,
  parameter int RING_DEPTH = 25600,
  parameter int TMO_W      = 16
) (
  input  logic                    clk_in,
  input  logic                    rstn,
  input  logic [NUM_CH*PTR_W-1:0] wp,
  input  logic [NUM_CH*PTR_W-1:0] rp,
  input  logic [PTR_W-1:0]        irq_threshold,
  input  logic [TMO_W-1:0]        irq_timeout,
  input  logic [NUM_CH-1:0]       irq_mask,
  input  logic [NUM_CH-1:0]       irq_ack,
  output logic [NUM_CH*CNT_W-1:0] data_available,
  output logic [NUM_CH-1:0]       irq_status,
  output logic                    irq
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    sonic_dma_irq_chan #(
      .PTR_W      (PTR_W),
      .RING_DEPTH (RING_DEPTH),
      .TMO_W      (TMO_W)
    ) u_chan (
      .clk_in    (clk_in),
      .rstn      (rstn),
      .wp        (wp[c*PTR_W +: PTR_W]),
      .rp        (rp[c*PTR_W +: PTR_W]),
      .threshold (irq_threshold),
      .timeout   (irq_timeout),
      .ack       (irq_ack[c]),
      .avail     (data_available[c*CNT_W +: CNT_W]),
      .status    (irq_status[c])
    );
  end

  // Mask only gates the summary line so pending state is never lost while masked.
  assign irq = |(irq_status & irq_mask);

endmodule

`default_nettype wire

// File: tb/tb_sonic_dma_irq_coalescer.sv
// tb_sonic_dma_irq_coalescer: directed + randomized checks against a behavioural ring/interrupt model.
// Revision 1.0 -- follows SONIC_IRQ_TIMEOUT_EN for the timeout expectations.
`default_nettype none

module tb_sonic_dma_irq_coalescer;

  localparam int NUM_CH = 4;
  localparam int PTR_W  = 15;
  localparam int DEPTH  = 8000;
  localparam int TMO_W  = 16;

  logic                    clk_in;
  logic                    rstn;
  logic [NUM_CH*PTR_W-1:0] wp, rp;
  logic [PTR_W-1:0]        wp_a [NUM_CH];
  logic [PTR_W-1:0]        rp_a [NUM_CH];
  logic [PTR_W-1:0]        irq_threshold;
  logic [TMO_W-1:0]        irq_timeout;
  logic [NUM_CH-1:0]       irq_mask;
  logic [NUM_CH-1:0]       irq_ack;
  logic [NUM_CH*32-1:0]    data_available;
  logic [NUM_CH-1:0]       irq_status;
  logic                    irq;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign wp[g*PTR_W +: PTR_W] = wp_a[g];
    assign rp[g*PTR_W +: PTR_W] = rp_a[g];
  end

  sonic_dma_irq_coalescer #(
    .NUM_CH     (NUM_CH),
    .PTR_W      (PTR_W),
    .RING_DEPTH (DEPTH),
    .TMO_W      (TMO_W)
  ) dut (
    .clk_in         (clk_in),
    .rstn           (rstn),
    .wp             (wp),
    .rp             (rp),
    .irq_threshold  (irq_threshold),
    .irq_timeout    (irq_timeout),
    .irq_mask       (irq_mask),
    .irq_ack        (irq_ack),
    .data_available (data_available),
    .irq_status     (irq_status),
    .irq            (irq)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: m_pend 0=nothing pending, 1=waiting below threshold, 2=interrupt raised.
  int m_pend [NUM_CH];
  int m_av   [NUM_CH];
  int m_wait [NUM_CH];

  function automatic int occ(input int w, input int r);
    if (w >= DEPTH || r >= DEPTH) return 0;
    return (w - r + DEPTH) % DEPTH;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pend[c] = 0;
      m_av[c]   = 0;
      m_wait[c] = 0;
    end
  endtask

  task automatic model_edge();
    int thr;
    int tmo;
    thr = (irq_threshold == 0) ? 1 : int'(irq_threshold);
    tmo = int'(irq_timeout);
    for (int c = 0; c < NUM_CH; c++) begin
      int a;
      a = m_av[c];
      if (m_pend[c] == 0) begin
        if (a >= thr) m_pend[c] = 2;
        else if (a > 0) begin
          m_pend[c] = 1;
          m_wait[c] = 0;
        end
      end else if (m_pend[c] == 1) begin
        if (a >= thr) m_pend[c] = 2;
        else if (a == 0) m_pend[c] = 0;
        else begin
`ifdef SONIC_IRQ_TIMEOUT_EN
          m_wait[c] = m_wait[c] + 1;
          if (tmo != 0 && m_wait[c] >= tmo) m_pend[c] = 2;
`endif
        end
      end else if (irq_ack[c]) begin
        m_pend[c] = 0;
      end
      m_av[c] = occ(int'(wp_a[c]), int'(rp_a[c]));
    end
  endtask

  task automatic compare(input string tag);
    logic [NUM_CH*32-1:0] e_dav;
    logic [NUM_CH-1:0]    e_st;
    for (int c = 0; c < NUM_CH; c++) begin
      e_dav[c*32 +: 32] = 32'(m_av[c]);
      e_st[c]           = (m_pend[c] == 2);
    end
    chk({tag, "_dav"}, data_available, e_dav);
    chk({tag, "_sts"}, irq_status, e_st);
    chk({tag, "_irq"}, irq, |(e_st & irq_mask));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk_in);
    model_edge();
    #1;
    compare(tag);
  endtask

  initial begin
    int first;
    rstn          = 1'b0;
    irq_threshold = 15'd300;
    irq_timeout   = '0;
    irq_mask      = 4'hF;
    irq_ack       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wp_a[c] = '0;
      rp_a[c] = '0;
    end
    model_reset();
    #1;
    compare("reset");
    @(posedge clk_in);
    #1;
    compare("reset_hold");
    rstn = 1'b1;

    // Wrapped occupancy and an out-of-range pointer.
    wp_a[0] = 15'd100;
    rp_a[0] = 15'd7950;
    wp_a[1] = 15'd50;
    cycle("wrap");
    chk("wrap_150", data_available[31:0], 150);
    chk("ch1_50", data_available[63:32], 50);
    wp_a[1] = 15'd9000;
    cycle("badptr");
    chk("badptr_zero", data_available[63:32], 0);
    wp_a[0] = '0;
    rp_a[0] = '0;
    wp_a[1] = '0;
    cycle("drain");
    cycle("drain");

    // Threshold crossing and ack.
    irq_threshold = 15'd64;
    wp_a[0] = 15'd64;
    cycle("thr1");
    chk("thr_lat1", irq_status[0], 0);
    cycle("thr2");
    chk("thr_lat2", irq_status[0], 1);
    wp_a[0] = '0;
    cycle("hold");
    cycle("hold");
    chk("fire_hold", irq_status[0], 1);
    irq_ack[0] = 1'b1;
    cycle("ack");
    irq_ack[0] = 1'b0;
    chk("ack_clr", irq_status[0], 0);
    cycle("post_ack");

    // Mask gates only irq.
    irq_mask = 4'b1101;
    wp_a[1]  = 15'd100;
    cycle("mask1");
    cycle("mask2");
    chk("mask_sts", irq_status[1], 1);
    chk("mask_irq", irq, 0);
    irq_mask = 4'b1111;
    #1;
    chk("unmask_irq", irq, 1);

    // Ack coinciding with a fresh fire condition.
    wp_a[1] = '0;
    cycle("race0");
    cycle("race0");
    irq_ack = 4'b0011;
    wp_a[1] = 15'd100;
    cycle("race_ack");
    irq_ack = '0;
    chk("race_clr", irq_status[1], 0);
    cycle("race_refire");
    chk("race_refire", irq_status[1], 1);

    // Asynchronous reset while ch2 is raised.
    wp_a[2] = 15'd200;
    cycle("ch2a");
    cycle("ch2b");
    chk("ch2_fire", irq_status[2], 1);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("arst_irq", irq, 0);
    compare("arst");
    for (int c = 0; c < NUM_CH; c++) begin
      wp_a[c] = '0;
      rp_a[c] = '0;
    end
    @(posedge clk_in);
    #1;
    compare("arst_hold");
    rstn = 1'b1;

    // Coalescing timeout with a small held backlog on ch3.
    irq_threshold = 15'd64;
    irq_timeout   = 16'd100;
    wp_a[3]       = 15'd5;
    first         = 0;
    for (int i = 1; i <= 110; i++) begin
      cycle("tmo");
      if (first == 0 && irq_status[3]) first = i;
    end
`ifdef SONIC_IRQ_TIMEOUT_EN
    chk("tmo_first", first, 102);
`else
    chk("tmo_first", first, 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        irq_threshold = 15'($urandom_range(0, 120));
        irq_timeout   = 16'($urandom_range(0, 30));
      end
      irq_mask = 4'($urandom);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          rp_a[c] = 15'($urandom_range(0, DEPTH - 1));
          wp_a[c] = 15'((int'(rp_a[c]) + int'($urandom_range(0, 150))) % DEPTH);
        end
        if ($urandom_range(0, 49) == 0) wp_a[c] = 15'($urandom_range(DEPTH, 32767));
        irq_ack[c] = ($urandom_range(0, 5) == 0);
      end
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
